// File: rtl/pacman_input_cond.sv
// pacman_input_cond: input conditioning in front of the pacman core.
// Merges PS/2 key events and the MiSTer joystick word, synchronises and
// debounces them, applies the optional screen-rotation remap, arbitrates each
// player's stick to 4-way, shapes coin requests into fixed-length pulses with a
// small queue, and drives the core's active-low in0/in1 buses from registers.
// Build option: define PACMAN_INPUT_DEBOUNCE_EN to instantiate the per-bit
// debounce counters; without it the stable vector is the synced vector.
//
// Raw/stable vector bit map:
//   [0] P1 right [1] P1 left [2] P1 down [3] P1 up [4] fire (P1 | P2)
//   [5] start1   [6] start2  [7] coin A  [8] coin B
//   [9] P2 right [10] P2 left [11] P2 down [12] P2 up
module pacman_input_cond #(
    parameter int CLK_DIV       = 24000,
    parameter int DEBOUNCE_MS   = 4,
    parameter int COIN_PULSE_MS = 100,
    parameter int COIN_GAP_MS   = 50
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    input  logic        cocktail,
    output logic [7:0]  in0_n,
    output logic [7:0]  in1_n,
    output logic        tick
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CT_MAX = (COIN_PULSE_MS > COIN_GAP_MS) ? COIN_PULSE_MS : COIN_GAP_MS;
    localparam int CT_W   = $clog2(CT_MAX + 1);

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             ps2_tog_q;
    logic [13:0]      key_sel;
    logic [13:0]      key_q;
    logic [12:0]      raw;
    logic [12:0]      sync1;
    logic [12:0]      sync2;
    logic [12:0]      stable;
    logic [3:0]       dirs     [2];
    logic [3:0]       dirs_q   [2];
    logic [3:0]       mask_q   [2];
    logic [3:0]       arb      [2];
    logic [1:0]       coin_in;
    logic [1:0]       coin_prev_q;
    logic [1:0]       coin_rise;
    logic [1:0]       dequeue;
    logic [1:0]       coin_on;
    logic [1:0]       pending  [2];
    logic [CT_W-1:0]  coin_tcnt[2];
    coin_state_t      coin_state[2];
    coin_state_t      coin_next [2];
    logic             unused_joy_hi;

    assign unused_joy_hi = ^joy[15:8];

    // 1 ms tick divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N)                          div_cnt <= '0;
        else if (div_cnt == DIV_W'(CLK_DIV-1)) div_cnt <= '0;
        else                                   div_cnt <= div_cnt + DIV_W'(1);
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV-1));

    // Scan-code decode into a one-hot key select; directions ignore the E0 prefix.
    always_comb begin
        key_sel = '0;
        unique case (ps2_key[7:0])
            8'h75:   key_sel[3] = 1'b1;
            8'h72:   key_sel[2] = 1'b1;
            8'h6B:   key_sel[1] = 1'b1;
            8'h74:   key_sel[0] = 1'b1;
            default: begin
                case (ps2_key[8:0])
                    9'h029, 9'h014: key_sel[4]  = 1'b1;
                    9'h005, 9'h016: key_sel[5]  = 1'b1;
                    9'h006, 9'h01E: key_sel[6]  = 1'b1;
                    9'h004, 9'h036: key_sel[7]  = 1'b1;
                    9'h02E:         key_sel[8]  = 1'b1;
                    9'h034:         key_sel[9]  = 1'b1;
                    9'h023:         key_sel[10] = 1'b1;
                    9'h02B:         key_sel[11] = 1'b1;
                    9'h02D:         key_sel[12] = 1'b1;
                    9'h01C:         key_sel[13] = 1'b1;
                    default:        key_sel     = '0;
                endcase
            end
        endcase
    end

    // Key state: a toggle change on ps2_key[10] loads the pressed bit into the selected key.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            ps2_tog_q <= 1'b0;
            key_q     <= '0;
        end else begin
            ps2_tog_q <= ps2_key[10];
            if (ps2_key[10] != ps2_tog_q)
                key_q <= (key_q & ~key_sel) | (key_sel & {14{ps2_key[9]}});
        end
    end

    // Raw vector: keys OR joystick; both players' sticks share joy[3:0].
    always_comb begin
        raw[3:0]  = key_q[3:0] | joy[3:0];
        raw[4]    = key_q[4] | key_q[13] | joy[4];
        raw[5]    = key_q[5] | joy[5];
        raw[6]    = key_q[6] | joy[6];
        raw[7]    = key_q[7] | joy[7];
        raw[8]    = key_q[8];
        raw[12:9] = key_q[12:9] | joy[3:0];
    end

    // Two-flop synchroniser on the whole raw vector.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef PACMAN_INPUT_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    logic [DB_W-1:0] db_cnt [13];

    // Per-bit debounce: a mismatch must persist for DEBOUNCE_MS ticks before it is accepted.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            stable <= '0;
            for (int i = 0; i < 13; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_MS-1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    // Rotation remap: a held up appears as left, left as down, down as right, right as up.
    always_comb begin
        dirs[0] = stable[3:0];
        dirs[1] = stable[12:9];
        if (rotate) begin
            dirs[0] = {stable[0],  stable[1],  stable[3],  stable[2]};
            dirs[1] = {stable[9],  stable[10], stable[12], stable[11]};
        end
    end

    // 4-way arbiter state: the mask follows the newest rising direction, up wins ties.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int p = 0; p < 2; p++) begin
                dirs_q[p] <= '0;
                mask_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                logic [3:0] rise;
                rise = dirs[p] & ~dirs_q[p];
                dirs_q[p] <= dirs[p];
                if      (rise[3]) mask_q[p] <= 4'b1000;
                else if (rise[2]) mask_q[p] <= 4'b0100;
                else if (rise[1]) mask_q[p] <= 4'b0010;
                else if (rise[0]) mask_q[p] <= 4'b0001;
            end
        end
    end

    // Arbiter output: only the newest direction, and only while it is still held.
    always_comb begin
        for (int p = 0; p < 2; p++) arb[p] = dirs[p] & mask_q[p];
    end

    assign coin_in   = {stable[8], stable[7]};
    assign coin_rise = coin_in & ~coin_prev_q;

    // Coin FSM state register.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) for (int c = 0; c < 2; c++) coin_state[c] <= COIN_IDLE;
        else          for (int c = 0; c < 2; c++) coin_state[c] <= coin_next[c];
    end

    // Coin FSM next state: IDLE drains the queue, PULSE and GAP last a fixed number of ticks.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            coin_next[c] = coin_state[c];
            dequeue[c]   = 1'b0;
            case (coin_state[c])
                COIN_IDLE: begin
                    if (pending[c] != 2'd0) begin
                        coin_next[c] = COIN_PULSE;
                        dequeue[c]   = 1'b1;
                    end
                end
                COIN_PULSE: if (tick && coin_tcnt[c] == CT_W'(COIN_PULSE_MS-1)) coin_next[c] = COIN_GAP;
                COIN_GAP:   if (tick && coin_tcnt[c] == CT_W'(COIN_GAP_MS-1))   coin_next[c] = COIN_IDLE;
                default:    coin_next[c] = COIN_IDLE;
            endcase
        end
    end

    // Coin FSM outputs: the coin bit is asserted for the whole PULSE state.
    always_comb begin
        for (int c = 0; c < 2; c++) coin_on[c] = (coin_state[c] == COIN_PULSE);
    end

    // Coin queue and tick counters: pending saturates at 3, a same-cycle edge and dequeue cancel.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            coin_prev_q <= '0;
            for (int c = 0; c < 2; c++) begin
                pending[c]   <= '0;
                coin_tcnt[c] <= '0;
            end
        end else begin
            coin_prev_q <= coin_in;
            for (int c = 0; c < 2; c++) begin
                if (coin_next[c] != coin_state[c])          coin_tcnt[c] <= '0;
                else if (tick && coin_state[c] != COIN_IDLE) coin_tcnt[c] <= coin_tcnt[c] + CT_W'(1);
                case ({coin_rise[c], dequeue[c]})
                    2'b10:   if (pending[c] != 2'd3) pending[c] <= pending[c] + 2'd1;
                    2'b01:   pending[c] <= pending[c] - 2'd1;
                    default: pending[c] <= pending[c];
                endcase
            end
        end
    end

    // Registered active-low output buses for the core.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            in0_n <= 8'hFF;
            in1_n <= 8'hFF;
        end else begin
            in0_n <= ~{2'b00, coin_on[1], coin_on[0], stable[4],
                       arb[0][2], arb[0][0], arb[0][1], arb[0][3]};
            in1_n <= ~{cocktail, stable[6], stable[5], 1'b0,
                       arb[1][2], arb[1][0], arb[1][1], arb[1][3]};
        end
    end

endmodule
